muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: operands latched on start, 32 one-bit steps, done pulses in the 33rd cycle.
// Divider datapath (ops 100-111) is built only when `MULDIV_DIV_EN is defined; otherwise those ops return 0.
module muldiv_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic [4:0]   rd_out,
  output logic         reg_write
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q;
  logic [2:0]     op_q;
  logic [2*n-1:0] acc_q, acc_d, mul_next, prod_s;
  logic [n-1:0]   opnd_q, mag_a, mag_b, res_d;
  logic [n:0]     mul_sum;
  logic           neg_q, accept;
  logic           a_sgn, b_sgn, sa, sb;

  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept)                cnt_q <= 5'd0;
      else if (state_q == CALC)  cnt_q <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign reg_write = done && (rd_out != 5'd0);

  // Both engines work on magnitudes; the sign is reapplied once at the end.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010: a_sgn = 1'b1;
`ifdef MULDIV_DIV_EN
      3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign sa    = a_sgn & a[n-1];
  assign sb    = b_sgn & b[n-1];
  assign mag_a = sa ? (~a + 1'b1) : a;
  assign mag_b = sb ? (~b + 1'b1) : b;

  // Shift-add: conditionally add multiplicand into the high half, then shift right with carry.
  assign mul_sum  = {1'b0, acc_q[2*n-1:n]} + (acc_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[n-1:1]};

`ifdef MULDIV_DIV_EN
  logic [n:0]   div_diff;
  logic         div_ge, bz_q;
  logic [n-1:0] a_q, quo, rem;
  logic [2*n-1:0] div_next;

  // Restoring step: acc holds {remainder, dividend/quotient}; the quotient bit shifts in at the bottom.
  assign div_diff = acc_q[2*n-1:n-1] - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[n];
  assign div_next = {(div_ge ? div_diff[n-1:0] : acc_q[2*n-2:n-1]), acc_q[n-2:0], div_ge};
  assign acc_d    = op_q[2] ? div_next : mul_next;
  assign quo      = acc_d[n-1:0];
  assign rem      = acc_d[2*n-1:n];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      bz_q <= 1'b0;
    end else if (accept) begin
      a_q  <= a;
      bz_q <= (b == '0);
    end
  end
`else
  assign acc_d = mul_next;
`endif

  assign prod_s = neg_q ? (~acc_d + 1'b1) : acc_d;

  always_comb begin
    res_d = (op_q == 3'b000) ? prod_s[n-1:0] : prod_s[2*n-1:n];
    if (op_q[2]) begin
`ifdef MULDIV_DIV_EN
      if (bz_q)
        res_d = op_q[1] ? a_q : '1;
      else if (op_q[1])
        res_d = neg_q ? (~rem + 1'b1) : rem;
      else
        res_d = neg_q ? (~quo + 1'b1) : quo;
`else
      res_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 3'b000;
      acc_q  <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      result <= '0;
      rd_out <= 5'd0;
    end else if (accept) begin
      op_q   <= op;
      acc_q  <= {{n{1'b0}}, mag_a};
      opnd_q <= mag_b;
      // Remainder follows the dividend; products and quotients follow sa^sb.
      neg_q  <= (op[2] & op[1]) ? sa : (sa ^ sb);
      rd_out <= rd_in;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      if (cnt_q == 5'd31) result <= res_d;
    end
  end

endmodule
